// File: rtl/vec_decode_stage.sv
// rtl/vec_decode_stage.sv - vector decode stage: lane-packed register file, immediate extension,
// pending-write scoreboard and the Decode/Execute pipeline register.
module vec_decode_stage #(
    parameter int LANES  = 3,
    parameter int LANE_W = 18,
    parameter int NREGS  = 16,
    parameter int IMM_W  = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_valid,
    input  logic [31:0]                 Instr,
    input  logic [1:0]                  RegSrc,
    input  logic [1:0]                  ImmSrcD,
    input  logic                        RegWriteD,
    input  logic [LANE_W-1:0]           pc_plus8,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        RegWriteW,
    input  logic [$clog2(NREGS)-1:0]    wa3w,
    input  logic [LANES*LANE_W-1:0]     wd3,
    output logic                        hazard,
    output logic                        valid_E,
    output logic [LANES*LANE_W-1:0]     rd1_E,
    output logic [LANES*LANE_W-1:0]     rd2_E,
    output logic [LANES*LANE_W-1:0]     ExtImm_E,
    output logic [$clog2(NREGS)-1:0]    ra1_E,
    output logic [$clog2(NREGS)-1:0]    ra2_E,
    output logic [$clog2(NREGS)-1:0]    wa3_E,
    output logic                        RegWrite_E
);
    localparam int AW = $clog2(NREGS);
    localparam int DW = LANES * LANE_W;
    localparam int EW = (IMM_W > LANE_W) ? IMM_W : LANE_W;
    localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

    logic [DW-1:0]    regs_q [NREGS];
    logic [DW-1:0]    regs_d [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;

    logic            valid_e_q, valid_e_d;
    logic [DW-1:0]   rd1_e_q, rd1_e_d, rd2_e_q, rd2_e_d, imm_e_q, imm_e_d;
    logic [AW-1:0]   ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, wa3_e_q, wa3_e_d;
    logic            regwrite_e_q, regwrite_e_d;

    logic [AW-1:0]    ra1, ra2, wa3;
    logic [DW-1:0]    rd1, rd2, ext_imm;
    logic [IMM_W-1:0] imm_field, imm_shl;
    logic [EW-1:0]    imm_wide;
    logic [NREGS-1:0] clr_w, pend_eff;
    logic             issue;

    // PC alias wins over write-through, so writes to it can never be observed.
    function automatic logic [DW-1:0] read_port(
        input logic [AW-1:0] addr,
        input logic [DW-1:0] stored,
        input logic          we,
        input logic [AW-1:0] waddr,
        input logic [DW-1:0] wdata,
        input logic [LANE_W-1:0] pc
    );
        if (addr == PC_IDX)            return {LANES{pc}};
        else if (we && waddr == addr)  return wdata;
        else                           return stored;
    endfunction

    always_comb begin
        ra1 = RegSrc[0] ? PC_IDX : AW'(Instr[3:0]);
        ra2 = RegSrc[1] ? AW'(Instr[7:4]) : AW'(Instr[11:8]);
        wa3 = AW'(Instr[15:12]);
        rd1 = read_port(ra1, regs_q[ra1], RegWriteW, wa3w, wd3, pc_plus8);
        rd2 = read_port(ra2, regs_q[ra2], RegWriteW, wa3w, wd3, pc_plus8);
    end

    always_comb begin
        imm_field = Instr[18+IMM_W-1:18];
        imm_shl   = imm_field << 2;
        case (ImmSrcD)
            2'b00:   imm_wide = EW'(imm_field);
            2'b01:   imm_wide = EW'($signed(imm_field));
            2'b10:   imm_wide = EW'(imm_shl);
            default: imm_wide = '0;
        endcase
        ext_imm = {LANES{imm_wide[LANE_W-1:0]}};
    end

    // A pending bit retired by writeback this cycle no longer blocks.
    always_comb begin
        clr_w    = RegWriteW ? (NREGS'(1) << wa3w) : '0;
        pend_eff = pending_q & ~clr_w;
        hazard   = instr_valid & ~flush &
                   (pend_eff[ra1] | pend_eff[ra2] | (pend_eff[wa3] & RegWriteD));
        issue    = instr_valid & ~hazard & ~stall & ~flush;
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
        if (RegWriteW && wa3w != PC_IDX) regs_d[wa3w] = wd3;

        pending_d = pending_q & ~clr_w;
        if (flush && valid_e_q && regwrite_e_q) pending_d[wa3_e_q] = 1'b0;
        if (issue && RegWriteD && wa3 != PC_IDX) pending_d[wa3] = 1'b1;
    end

    always_comb begin
        valid_e_d    = valid_e_q;
        rd1_e_d      = rd1_e_q;
        rd2_e_d      = rd2_e_q;
        imm_e_d      = imm_e_q;
        ra1_e_d      = ra1_e_q;
        ra2_e_d      = ra2_e_q;
        wa3_e_d      = wa3_e_q;
        regwrite_e_d = regwrite_e_q;
        if (flush) begin
            valid_e_d = 1'b0;
        end else if (!stall) begin
            valid_e_d = issue;
            if (issue) begin
                rd1_e_d      = rd1;
                rd2_e_d      = rd2;
                imm_e_d      = ext_imm;
                ra1_e_d      = ra1;
                ra2_e_d      = ra2;
                wa3_e_d      = wa3;
                regwrite_e_d = RegWriteD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            pending_q    <= '0;
            valid_e_q    <= 1'b0;
            rd1_e_q      <= '0;
            rd2_e_q      <= '0;
            imm_e_q      <= '0;
            ra1_e_q      <= '0;
            ra2_e_q      <= '0;
            wa3_e_q      <= '0;
            regwrite_e_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
            pending_q    <= pending_d;
            valid_e_q    <= valid_e_d;
            rd1_e_q      <= rd1_e_d;
            rd2_e_q      <= rd2_e_d;
            imm_e_q      <= imm_e_d;
            ra1_e_q      <= ra1_e_d;
            ra2_e_q      <= ra2_e_d;
            wa3_e_q      <= wa3_e_d;
            regwrite_e_q <= regwrite_e_d;
        end
    end

    assign valid_E    = valid_e_q;
    assign rd1_E      = rd1_e_q;
    assign rd2_E      = rd2_e_q;
    assign ExtImm_E   = imm_e_q;
    assign ra1_E      = ra1_e_q;
    assign ra2_E      = ra2_e_q;
    assign wa3_E      = wa3_e_q;
    assign RegWrite_E = regwrite_e_q;
endmodule

// File: tb/tb_vec_decode_stage.sv
// tb/tb_vec_decode_stage.sv - directed self-checking bench for vec_decode_stage.
module tb_vec_decode_stage;
    localparam int LANES = 3, LANE_W = 18, NREGS = 16, IMM_W = 10;
    localparam int DW = LANES * LANE_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_valid;
    logic [31:0]     Instr;
    logic [1:0]      RegSrc, ImmSrcD;
    logic            RegWriteD;
    logic [LANE_W-1:0] pc_plus8;
    logic            stall, flush, RegWriteW;
    logic [3:0]      wa3w;
    logic [DW-1:0]   wd3;
    logic            hazard, valid_E, RegWrite_E;
    logic [DW-1:0]   rd1_E, rd2_E, ExtImm_E;
    logic [3:0]      ra1_E, ra2_E, wa3_E;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] v_r2, v_r5, hold_rd1;
    logic [3:0]    hold_ra1;

    vec_decode_stage #(.LANES(LANES), .LANE_W(LANE_W), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .Instr(Instr), .RegSrc(RegSrc),
        .ImmSrcD(ImmSrcD), .RegWriteD(RegWriteD), .pc_plus8(pc_plus8), .stall(stall),
        .flush(flush), .RegWriteW(RegWriteW), .wa3w(wa3w), .wd3(wd3), .hazard(hazard),
        .valid_E(valid_E), .rd1_E(rd1_E), .rd2_E(rd2_E), .ExtImm_E(ExtImm_E),
        .ra1_E(ra1_E), .ra2_E(ra2_E), .wa3_E(wa3_E), .RegWrite_E(RegWrite_E)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] ra1, input logic [3:0] ra2,
                                       input logic [3:0] wa3, input logic [9:0] imm);
        return {4'h0, imm, 2'b00, wa3, ra2, 4'h0, ra1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; instr_valid = 1'b0; Instr = '0; RegSrc = '0; ImmSrcD = '0;
        RegWriteD = 1'b0; pc_plus8 = '0; stall = 1'b0; flush = 1'b0;
        RegWriteW = 1'b0; wa3w = '0; wd3 = '0;
        v_r2 = {18'h3FFFF, 18'h00001, 18'h2AAAA};
        v_r5 = {18'h12345, 18'h0BEEF, 18'h00F0F};
        step(); step();
        check("rst_valid", 64'(valid_E), 64'd0);
        check("rst_rd1", 64'(rd1_E), 64'd0);
        check("rst_imm", 64'(ExtImm_E), 64'd0);
        check("rst_wa3", 64'(wa3_E), 64'd0);

        rst = 1'b1;
        instr_valid = 1'b1; Instr = mk(4'd3, 4'd0, 4'd0, 10'd0);
        #1 check("r3_hazard", 64'(hazard), 64'd0);
        step();
        check("r3_valid", 64'(valid_E), 64'd1);
        check("r3_rd1", 64'(rd1_E), 64'd0);
        check("r3_ra1", 64'(ra1_E), 64'd3);

        // Write-through: W writes r2 while D reads it
        Instr = mk(4'd2, 4'd0, 4'd0, 10'd0);
        RegWriteW = 1'b1; wa3w = 4'd2; wd3 = v_r2;
        step();
        RegWriteW = 1'b0;
        check("wt_rd1", 64'(rd1_E), 64'(v_r2));
        Instr = mk(4'd0, 4'd2, 4'd0, 10'd0);
        step();
        check("r2_rd2_stored", 64'(rd2_E), 64'(v_r2));

        // RAW on r5
        Instr = mk(4'd0, 4'd0, 4'd5, 10'd0); RegWriteD = 1'b1;
        step();
        check("w5_valid", 64'(valid_E), 64'd1);
        check("w5_wa3", 64'(wa3_E), 64'd5);
        check("w5_regwrite", 64'(RegWrite_E), 64'd1);
        Instr = mk(4'd5, 4'd0, 4'd0, 10'd0); RegWriteD = 1'b0;
        #1 check("raw_hazard0", 64'(hazard), 64'd1);
        step();
        check("raw_bubble0", 64'(valid_E), 64'd0);
        check("raw_hazard1", 64'(hazard), 64'd1);
        step();
        check("raw_bubble1", 64'(valid_E), 64'd0);
        RegWriteW = 1'b1; wa3w = 4'd5; wd3 = v_r5;
        #1 check("raw_clear_hazard", 64'(hazard), 64'd0);
        step();
        RegWriteW = 1'b0;
        check("raw_issue_valid", 64'(valid_E), 64'd1);
        check("raw_issue_rd1", 64'(rd1_E), 64'(v_r5));

        // Immediate modes
        ImmSrcD = 2'b01; Instr = mk(4'd0, 4'd0, 4'd0, 10'h3FF);
        step();
        check("imm_sext", 64'(ExtImm_E), 64'({3{18'h3FFFF}}));
        ImmSrcD = 2'b10; Instr = mk(4'd0, 4'd0, 4'd0, 10'h001);
        step();
        check("imm_shl2", 64'(ExtImm_E), 64'({3{18'h00004}}));
        ImmSrcD = 2'b00; Instr = mk(4'd0, 4'd0, 4'd0, 10'h3FF);
        step();
        check("imm_zext", 64'(ExtImm_E), 64'({3{18'h003FF}}));
        ImmSrcD = 2'b11;
        step();
        check("imm_zero", 64'(ExtImm_E), 64'd0);
        ImmSrcD = 2'b00;

        // Stall then flush of a pending write to r7
        Instr = mk(4'd1, 4'd0, 4'd7, 10'd0); RegWriteD = 1'b1;
        step();
        check("w7_wa3", 64'(wa3_E), 64'd7);
        hold_rd1 = rd1_E; hold_ra1 = ra1_E;
        Instr = mk(4'd3, 4'd0, 4'd0, 10'd0); RegWriteD = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 64'(valid_E), 64'd1);
            check("stall_ra1", 64'(ra1_E), 64'(hold_ra1));
            check("stall_rd1", 64'(rd1_E), 64'(hold_rd1));
            check("stall_wa3", 64'(wa3_E), 64'd7);
            check("stall_regwrite", 64'(RegWrite_E), 64'd1);
        end
        stall = 1'b0; flush = 1'b1; Instr = mk(4'd7, 4'd0, 4'd0, 10'd0);
        #1 check("flush_hazard_masked", 64'(hazard), 64'd0);
        step();
        flush = 1'b0;
        check("flush_valid", 64'(valid_E), 64'd0);
        #1 check("r7_no_hazard", 64'(hazard), 64'd0);
        step();
        check("r7_issue", 64'(valid_E), 64'd1);

        // PC alias
        RegSrc = 2'b01; pc_plus8 = 18'h00108; Instr = mk(4'd0, 4'd0, 4'd0, 10'd0);
        step();
        check("pc_rd1", 64'(rd1_E), 64'({3{18'h00108}}));
        check("pc_ra1", 64'(ra1_E), 64'd15);
        RegSrc = 2'b00; Instr = mk(4'd0, 4'd15, 4'd0, 10'd0);
        RegWriteW = 1'b1; wa3w = 4'd15; wd3 = v_r5;
        step();
        RegWriteW = 1'b0;
        check("pc_wt_ignored", 64'(rd2_E), 64'({3{18'h00108}}));
        pc_plus8 = 18'h00200;
        step();
        check("pc_after_write", 64'(rd2_E), 64'({3{18'h00200}}));

        // A write targeting the PC alias never becomes pending
        Instr = mk(4'd0, 4'd0, 4'd15, 10'd0); RegWriteD = 1'b1;
        step();
        Instr = mk(4'd0, 4'd0, 4'd15, 10'd0);
        #1 check("pc_wa3_no_hazard", 64'(hazard), 64'd0);
        RegWriteD = 1'b0;

        // Asynchronous reset mid-operation
        Instr = mk(4'd0, 4'd0, 4'd9, 10'd0); RegWriteD = 1'b1;
        step();
        check("w9_valid", 64'(valid_E), 64'd1);
        #2 rst = 1'b0;
        #1 check("async_rst_valid", 64'(valid_E), 64'd0);
        check("async_rst_wa3", 64'(wa3_E), 64'd0);
        step();
        rst = 1'b1; RegWriteD = 1'b0; Instr = mk(4'd9, 4'd2, 4'd0, 10'd0);
        #1 check("post_rst_r9_no_hazard", 64'(hazard), 64'd0);
        step();
        check("post_rst_issue", 64'(valid_E), 64'd1);
        check("post_rst_r2_cleared", 64'(rd2_E), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vec_decode_stage.md
Name: vec_decode_stage

Overview:
Parametrised decode stage for the vector filter CPU. It holds a multi-lane register file and selects the source registers. It extends the immediate in several modes and tracks pending writes in a scoreboard. Decoded operands are registered into a Decode/Execute pipeline register, with stall, flush and RAW-hazard bubble insertion. It sits between fetch and execute. Writeback feeds it through the W-stage write port.

Parameters:
LANES, 3, number of vector lanes
LANE_W, 18, bits per lane
NREGS, 16, architectural registers (power of 2, ≥4); last index is the PC alias
IMM_W, 10, immediate field width taken from Instr[18+IMM_W-1:18]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
instr_valid  in  1  Instr holds a live instruction this cycle
Instr  in  32  instruction word; ra1=Instr[3:0], ra2=Instr[11:8] or Instr[7:4], wa3=Instr[15:12]
RegSrc  in  2  [0]: ra1 = PC alias; [1]: ra2 = Instr[7:4] instead of Instr[11:8]
ImmSrcD  in  2  00 zero-ext, 01 sign-ext, 10 zero-ext shifted left 2, 11 zero
RegWriteD  in  1  instruction writes wa3
pc_plus8  in  LANE_W  value returned for the PC alias, broadcast to all lanes
stall  in  1  execute not ready; hold E register
flush  in  1  kill D and E contents
RegWriteW  in  1  writeback enable
wa3w  in  log2(NREGS)  writeback address
wd3  in  LANES*LANE_W  writeback data, lane-packed
hazard  out  1  combinational; D instruction blocked, fetch must hold
valid_E  out  1  E register holds a live instruction
rd1_E, rd2_E  out  LANES*LANE_W  registered operands
ExtImm_E  out  LANES*LANE_W  registered immediate, broadcast per lane
ra1_E, ra2_E, wa3_E  out  log2(NREGS)  registered addresses (for forwarding)
RegWrite_E  out  1  registered RegWriteD

Behaviour:
- Reset (rst=0, async): all E outputs 0, valid_E=0, all scoreboard bits 0, all registers 0.
- Register file writes on the rising edge when RegWriteW=1. A write to index NREGS-1 is ignored.
- Reads are combinational with write-through: if RegWriteW and wa3w equals the read address, the read returns wd3.
- A read of index NREGS-1 returns pc_plus8 in every lane.
- Immediate: IMM_W bits are extended to LANE_W in every lane.
  - If IMM_W > LANE_W, truncate to the LSBs.
  - Mode 10: the field is shifted left 2 before zero-extension, with overflow dropped.
- Scoreboard, one bit per register:
  - Set at issue when RegWriteD=1 and wa3 ≠ NREGS-1.
  - Cleared when RegWriteW writes that index.
  - If set and clear hit the same index in the same cycle, set wins.
- hazard = instr_valid & !flush & (pending[ra1] | pending[ra2] | pending[wa3]&RegWriteD). A pending bit being cleared this cycle by RegWriteW does not count. Reads of the PC alias never hazard.
- Issue = instr_valid & !hazard & !stall & !flush. On issue, the E register loads all decoded fields and valid_E←1.
- Priority per cycle is flush > stall > hazard:
  - flush: valid_E←0 next edge; if valid_E & RegWrite_E, clear pending[wa3_E]; D instruction is not issued.
  - stall (no flush): E register holds all values; no issue; the scoreboard still clears from W.
  - hazard (no stall/flush): bubble, valid_E←0 and the other E fields are don't-care-but-stable (hold).
  - none: issue if instr_valid, else valid_E←0.
- Latency: one cycle from D to E. A write in cycle N is visible to a D read in cycle N via write-through.
- Reset asserted mid-operation discards in-flight state immediately.

Test Plan:
- Reset with rst=0, then release, issue a read of r3 → valid_E=1, rd1_E=0, hazard=0.
- W writes r2 = {18'h3FFFF, 18'h00001, 18'h2AAAA} while D reads r2 in the same cycle → rd1_E equals that value next cycle.
- Issue a write to r5 (RegWriteD=1), then a read of r5 → hazard=1 and valid_E=0 until RegWriteW with wa3w=5. In that cycle hazard=0 and the read issues with the new data.
- ImmSrcD=01 with Instr[27:18]=10'h3FF → ExtImm_E lanes = 18'h3FFFF. ImmSrcD=10 with the field 10'h001 → lanes = 18'h00004.
- stall=1 for 3 cycles with valid_E=1 → E outputs are unchanged. Assert flush with RegWrite_E=1 and wa3_E=7 → valid_E=0 and pending[7] cleared, so a later read of r7 does not hazard.
- RegSrc=01 with pc_plus8=18'h00108 → rd1_E lanes all 18'h00108. A W write to r15 leaves subsequent r15 reads equal to pc_plus8.
